// File: rtl/aes_inv_fsm_controller.sv
// Control FSM for the byte-serial AES inverse cipher datapath.
// Walks round keys NR..0 and owns the byte, column and round counters.
module aes_inv_fsm_controller #(
  parameter int NR      = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               key_ready,
  output logic               busy,
  output logic               done,
  output logic               en_load,
  output logic               en_add_round_key,
  output logic               en_inv_shift_rows,
  output logic               en_inv_sub_bytes,
  output logic               en_inv_mix_column,
  output logic [3:0]         byte_idx,
  output logic [1:0]         col_idx,
  output logic [ROUND_W-1:0] key_round_addr
);

  typedef enum logic [2:0] {
    IDLE,
    WAITKEY,
    LOAD,
    ADDKEY,
    INVSHIFT,
    INVSUB,
    INVMIX,
    DONE
  } state_t;

  localparam logic [ROUND_W-1:0] RN = ROUND_W'(NR);

  state_t             state;
  logic [ROUND_W-1:0] round_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_idx  <= '0;
      col_idx   <= '0;
      round_num <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            round_num <= RN;
            state     <= key_ready ? LOAD : WAITKEY;
          end
        end
        WAITKEY: begin
          if (key_ready) state <= LOAD;
        end
        LOAD: begin
          byte_idx <= byte_idx + 4'd1;
          if (byte_idx == 4'd15) state <= ADDKEY;
        end
        ADDKEY: begin
          byte_idx <= byte_idx + 4'd1;
          if (byte_idx == 4'd15) begin
            // the first key is followed directly by InvShiftRows
            if (round_num == RN) begin
              state     <= INVSHIFT;
              round_num <= round_num - 1'b1;
            end else if (round_num == '0) begin
              state <= DONE;
            end else begin
              state <= INVMIX;
            end
          end
        end
        INVSHIFT: begin
          state <= INVSUB;
        end
        INVSUB: begin
          byte_idx <= byte_idx + 4'd1;
          if (byte_idx == 4'd15) state <= ADDKEY;
        end
        INVMIX: begin
          col_idx <= col_idx + 2'd1;
          if (col_idx == 2'd3) begin
            state <= INVSHIFT;
            if (round_num != '0) round_num <= round_num - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign en_load           = (state == LOAD);
  assign en_add_round_key  = (state == ADDKEY);
  assign en_inv_shift_rows = (state == INVSHIFT);
  assign en_inv_sub_bytes  = (state == INVSUB);
  assign en_inv_mix_column = (state == INVMIX);
  assign key_round_addr    = round_num;

endmodule

// File: tb/tb_aes_inv_fsm_controller.sv
// Randomized bench for aes_inv_fsm_controller (NR=10 and NR=14 builds)
// against a phase-list model of the inverse cipher schedule.
module tb_aes_inv_fsm_controller;

  localparam int C_IDLE  = 0;
  localparam int C_WAIT  = 1;
  localparam int C_LOAD  = 2;
  localparam int C_ADD   = 3;
  localparam int C_SHIFT = 4;
  localparam int C_SUB   = 5;
  localparam int C_MIX   = 6;
  localparam int C_DONE  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, key_ready_a;
  logic       busy_a, done_a, el_a, ea_a, es_a, eb_a, em_a;
  logic [3:0] bi_a, ka_a;
  logic [1:0] ci_a;

  logic       rst_b, start_b, key_ready_b;
  logic       busy_b, done_b, el_b, ea_b, es_b, eb_b, em_b;
  logic [3:0] bi_b, ka_b;
  logic [1:0] ci_b;

  aes_inv_fsm_controller #(.NR(10), .ROUND_W(4)) u_dut (
    .clk(clk), .rst(rst_a), .start(start_a), .key_ready(key_ready_a),
    .busy(busy_a), .done(done_a),
    .en_load(el_a), .en_add_round_key(ea_a),
    .en_inv_shift_rows(es_a), .en_inv_sub_bytes(eb_a),
    .en_inv_mix_column(em_a),
    .byte_idx(bi_a), .col_idx(ci_a), .key_round_addr(ka_a)
  );

  aes_inv_fsm_controller #(.NR(14), .ROUND_W(4)) u_dut14 (
    .clk(clk), .rst(rst_b), .start(start_b), .key_ready(key_ready_b),
    .busy(busy_b), .done(done_b),
    .en_load(el_b), .en_add_round_key(ea_b),
    .en_inv_shift_rows(es_b), .en_inv_sub_bytes(eb_b),
    .en_inv_mix_column(em_b),
    .byte_idx(bi_b), .col_idx(ci_b), .key_round_addr(ka_b)
  );

  // {busy, done, load, ark, isr, isb, imc, byte, col, addr}
  logic [16:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, el_a, ea_a, es_a, eb_a, em_a,
                  bi_a, ci_a, ka_a};
  assign obs_b = {busy_b, done_b, el_b, ea_b, es_b, eb_b, em_b,
                  bi_b, ci_b, ka_b};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [16:0] exp_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(int code, int idx, int rnd);
    logic [4:0] en;
    logic [3:0] b;
    logic [1:0] c;
    logic [3:0] r;
    en = '0;
    b  = '0;
    c  = '0;
    r  = rnd[3:0];
    case (code)
      C_LOAD:  en = 5'b10000;
      C_ADD:   en = 5'b01000;
      C_SHIFT: en = 5'b00100;
      C_SUB:   en = 5'b00010;
      C_MIX:   en = 5'b00001;
      default: en = 5'b00000;
    endcase
    if (code == C_LOAD || code == C_ADD || code == C_SUB) b = idx[3:0];
    if (code == C_MIX) c = idx[1:0];
    return {code != C_IDLE, code == C_DONE, en, b, c, r};
  endfunction

  // One block of the inverse cipher, phase by phase
  function automatic void build(int nr, int wait_k);
    for (int i = 0; i < wait_k; i++) exp_q.push_back(mk(C_WAIT, 0, nr));
    for (int b = 0; b < 16; b++) exp_q.push_back(mk(C_LOAD, b, nr));
    for (int r = nr; r >= 0; r--) begin
      for (int b = 0; b < 16; b++) exp_q.push_back(mk(C_ADD, b, r));
      if (r == 0) break;
      if (r < nr)
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(C_MIX, c, r));
      exp_q.push_back(mk(C_SHIFT, 0, r - 1));
      for (int b = 0; b < 16; b++) exp_q.push_back(mk(C_SUB, b, r - 1));
    end
    exp_q.push_back(mk(C_DONE, 0, 0));
    exp_q.push_back(mk(C_IDLE, 0, 0));
  endfunction

  function automatic logic [16:0] get_obs(int sel);
    return (sel == 0) ? obs_a : obs_b;
  endfunction

  task automatic set_in(int sel, logic r, logic s, logic kr);
    if (sel == 0) begin
      rst_a = r; start_a = s; key_ready_a = kr;
    end else begin
      rst_b = r; start_b = s; key_ready_b = kr;
    end
  endtask

  task automatic gap(int sel, int n);
    set_in(sel, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc = -1;
      check("idle", get_obs(sel), mk(C_IDLE, 0, 0));
    end
  endtask

  task automatic run(int sel, int nr, int wait_k, int abort_at);
    int n;
    int cnt[5];
    logic [16:0] o, e;
    logic kr;
    exp_q.delete();
    build(nr, wait_k);
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(mk(C_IDLE, 0, 0));
    end
    n = exp_q.size();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    set_in(sel, 1'b0, 1'b1, wait_k == 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      cyc = k;
      o = get_obs(sel);
      e = exp_q[k-1];
      check("trace", o, e);
      for (int i = 0; i < 5; i++) cnt[i] += int'(o[14-i]);
      // inputs below are sampled in the state of cycle k
      if (k < wait_k)       kr = 1'b0;
      else if (k == wait_k) kr = 1'b1;
      else                  kr = 1'($urandom_range(0, 1));
      if (abort_at > 0 && k == abort_at)
        set_in(sel, 1'b1, 1'b0, kr);
      else if (!e[16] || k == n)
        set_in(sel, 1'b0, 1'b0, kr);
      else if (k == 50 || e[15])
        set_in(sel, 1'b0, 1'b1, kr);
      else
        set_in(sel, 1'b0, 1'($urandom_range(0, 7) == 0), kr);
    end
    set_in(sel, 1'b0, 1'b0, kr);
    if (abort_at == 0) begin
      cyc = n;
      check("n_load", cnt[0], 16);
      check("n_ark",  cnt[1], 16 * (nr + 1));
      check("n_isr",  cnt[2], nr);
      check("n_isb",  cnt[3], 16 * nr);
      check("n_imc",  cnt[4], 4 * (nr - 1));
    end
  endtask

  initial begin
    set_in(0, 1'b1, 1'b0, 1'b0);
    set_in(1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", obs_a, mk(C_IDLE, 0, 0));
    check("rst_b", obs_b, mk(C_IDLE, 0, 0));
    set_in(0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);
    gap(0, 5);
    gap(1, 5);
    run(0, 10, 0, 0);
    gap(0, 3);
    run(0, 10, 7, 0);
    gap(0, 2);
    run(0, 10, 0, 200);
    run(0, 10, 0, 0);
    for (int t = 0; t < 3; t++) begin
      gap(0, $urandom_range(0, 4));
      run(0, 10, $urandom_range(0, 6), 0);
    end
    run(1, 14, 0, 0);
    gap(1, 2);
    run(1, 14, $urandom_range(1, 5), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_fsm_controller.md
Name: aes_inv_fsm_controller

Overview:
- Control FSM for the byte-serial AES inverse cipher (decryption) datapath.
- Sequences load, AddRoundKey, InvShiftRows, InvSubBytes and InvMixColumns over round keys NR..0, and owns the byte, column and round counters.
- Sits beside the encryption controller and reuses the shared state register file, S-box/inverse S-box unit and round-key store.
- Round keys are precomputed by key expansion; the controller reads them by round address.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- ROUND_W, 4, width of the round counter and the key address.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- start, input, 1, begin decryption; sampled only in IDLE.
- key_ready, input, 1, round-key store holds all NR+1 keys; sampled only in IDLE and WAITKEY.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse in DONE; plaintext is valid in the state register.
- en_load, output, 1, capture ciphertext byte byte_idx.
- en_add_round_key, output, 1, XOR byte byte_idx with key byte byte_idx of round key_round_addr.
- en_inv_shift_rows, output, 1, one-cycle whole-state InvShiftRows.
- en_inv_sub_bytes, output, 1, replace byte byte_idx with InvSbox(byte).
- en_inv_mix_column, output, 1, InvMixColumns on column col_idx.
- byte_idx, output, 4, byte pointer.
- col_idx, output, 2, column pointer.
- key_round_addr, output, ROUND_W, round-key address; equals round_num.

Behaviour:
- Reset: state IDLE; all enables, busy and done are 0; byte_idx=0, col_idx=0, round_num=0. Reset mid-operation returns to IDLE on the next edge with the same values and no done pulse.
- Timing convention: edge 0 samples start; "cycle k" means the outputs after edge k.
- Enables are decoded combinationally from the state register and the counters. Only one enable is high in any cycle.
- IDLE: start=1 & key_ready=1 -> LOAD. start=1 & key_ready=0 -> WAITKEY. Either transition sets round_num=NR.
- WAITKEY: busy=1, no enables. Goes to LOAD on the first cycle key_ready=1. start is ignored here.
- LOAD: en_load=1 for 16 cycles, byte_idx 0..15. At byte 15 -> ADDKEY with byte_idx cleared.
- ADDKEY: en_add_round_key=1 for 16 cycles, byte_idx 0..15. At byte 15:
  - round_num==NR -> INVSHIFT, round_num decrements.
  - round_num==0 -> DONE.
  - otherwise -> INVMIX.
- INVSHIFT: en_inv_shift_rows=1 for 1 cycle -> INVSUB.
- INVSUB: en_inv_sub_bytes=1 for 16 cycles, byte_idx 0..15 -> ADDKEY.
- INVMIX: en_inv_mix_column=1 for 4 cycles, col_idx 0..3. At column 3 -> INVSHIFT, round_num decrements.
- DONE: done=1 for 1 cycle, busy=1 -> IDLE unconditionally. start in DONE is ignored.
- Counters:
  - byte_idx and col_idx are held at 0 outside their counting states and wrap 15->0 / 3->0 on state exit.
  - round_num never underflows; the decrement happens only when round_num is 1..NR.
- key_round_addr sequence across ADDKEY visits: NR, NR-1, ..., 0.
- start while busy=1 is ignored with no queueing. key_ready deasserting after LOAD begins is ignored.
- Latency with key_ready=1: LOAD occupies cycles 1..16, DONE is cycle 37*NR+29 (399 for NR=10, 473 for NR=12, 547 for NR=14). busy is high in cycles 1..37*NR+29.
- Per block, NR=10: en_load 16 cycles, en_add_round_key 176, en_inv_sub_bytes 160, en_inv_shift_rows 10, en_inv_mix_column 36.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> all outputs 0, busy=0, byte_idx=0, col_idx=0.
- NR=10, key_ready=1, start pulse at edge 0 -> done only in cycle 399; enable counts exactly 16/176/160/10/36; key_round_addr sequence 10,9,...,0; en_inv_mix_column never follows the round-0 ADDKEY.
- key_ready=0 at start, raised after 7 cycles -> WAITKEY with busy=1 and no enables for 7 cycles, then LOAD; done arrives 7 cycles later than nominal (cycle 406).
- start pulsed again at cycles 50 and 399 (DONE) -> ignored; single done pulse; IDLE at cycle 400.
- rst=1 at cycle 200 (inside a round) -> next cycle is IDLE with reset values and no done; a new start then yields done 399 cycles later.
- NR=14 build -> done at cycle 547; key_round_addr runs 14..0; en_inv_mix_column total 52 cycles.
